// File: rtl/op_uram_drain.sv
// Drains NUM_URAM banks of URAM in bank-major order into an AXI-Stream master.
// Read issue is credit-limited so returning data always fits in the skid FIFO.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing reads, limited by in-flight plus FIFO credit
// DRAIN | all reads issued, waiting for the last beat to handshake
// DONE  | one-cycle done pulse
module op_uram_drain #(
    parameter int NUM_URAM        = 64,
    parameter int URAM_ADDR_WIDTH = 14,
    parameter int READ_LATENCY    = 3,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [URAM_ADDR_WIDTH:0]   rd_len,
    output logic [NUM_URAM-1:0]        uram_enb,
    output logic [NUM_URAM-1:0]        uram_doutb_valid,
    output logic [URAM_ADDR_WIDTH-1:0] uram_addrb,
    input  logic [15:0]                uram_doutb,
    output logic [15:0]                m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       busy,
    output logic                       done
);
    localparam int BW  = (NUM_URAM > 1) ? $clog2(NUM_URAM) : 1;
    localparam int IFW = $clog2(READ_LATENCY + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                     state;
    logic [BW-1:0]              bank;
    logic [URAM_ADDR_WIDTH-1:0] addr;
    logic [URAM_ADDR_WIDTH-1:0] addr_hold;
    logic [URAM_ADDR_WIDTH:0]   len;
    logic [IFW-1:0]             in_flight;
    logic [NUM_URAM-1:0]        vld_sr [READ_LATENCY];
    logic [READ_LATENCY-1:0]    last_sr;
    logic [16:0]                fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [CW-1:0]              fifo_count;

    logic credit;
    logic addr_wrap;
    logic issue_last;
    logic issue;
    logic ret;
    logic ret_last;
    logic pop;

    assign credit     = (32'(in_flight) + 32'(fifo_count)) < 32'(FIFO_DEPTH);
    assign addr_wrap  = ({1'b0, addr} == (len - 1'b1));
    assign issue_last = addr_wrap && (bank == BW'(NUM_URAM - 1));
    assign issue      = !rst && (state == ISSUE) && credit;
    assign ret        = |vld_sr[READ_LATENCY-1];
    assign ret_last   = last_sr[READ_LATENCY-1];
    assign pop        = m_axis_tvalid && m_axis_tready;

    assign uram_enb         = issue ? (NUM_URAM'(1) << bank) : '0;
    assign uram_addrb       = rst ? '0 : (issue ? addr : addr_hold);
    assign uram_doutb_valid = rst ? '0 : vld_sr[READ_LATENCY-1];
    assign m_axis_tvalid    = !rst && (fifo_count != '0);
    assign m_axis_tdata     = fifo_mem[rd_ptr][15:0];
    assign m_axis_tlast     = m_axis_tvalid && fifo_mem[rd_ptr][16];
    assign busy             = !rst && (state != IDLE);
    assign done             = !rst && (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bank      <= '0;
            addr      <= '0;
            addr_hold <= '0;
            len       <= '0;
        end else begin
            if (issue) begin
                addr_hold <= addr;
                if (addr_wrap) begin
                    addr <= '0;
                    if (!issue_last) bank <= bank + 1'b1;
                end else begin
                    addr <= addr + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        len   <= rd_len;
                        bank  <= '0;
                        addr  <= '0;
                        state <= (rd_len == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue && issue_last) state <= DRAIN;
                end
                DRAIN: begin
                    if (in_flight == '0 && fifo_count == CW'(1) && pop && m_axis_tlast)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Enable and last-word tag ride the same pipeline as the bank read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) vld_sr[i] <= '0;
            last_sr <= '0;
        end else begin
            vld_sr[0]  <= uram_enb;
            last_sr[0] <= issue && issue_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight <= '0;
        end else begin
            case ({issue, ret})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ret) fifo_mem[wr_ptr] <= {ret_last, uram_doutb};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (ret) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({ret, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule
